// File: rtl/intdiv_iter.sv
// Sequential restoring integer divider for the RISC-V M extension.
// Processes IDIV_BITSPERCYCLE quotient bits per cycle; Done pulses with Quot/Rem valid.
package cvw_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned IDIV_BITSPERCYCLE;
  } cvw_t;
  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, IDIV_BITSPERCYCLE: 1};
endpackage

module intdiv_iter #(
  parameter cvw_pkg::cvw_t P = cvw_pkg::CVW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Flush,
  input  logic              Signed,
  input  logic              W64,
  input  logic [P.XLEN-1:0] SrcA,
  input  logic [P.XLEN-1:0] SrcB,
  output logic              Busy,
  output logic              Done,
  output logic [P.XLEN-1:0] Quot,
  output logic [P.XLEN-1:0] Rem
);
  localparam int unsigned       XLEN      = P.XLEN;
  localparam int unsigned       B         = P.IDIV_BITSPERCYCLE;
  localparam int unsigned       CW        = $clog2(XLEN / B);
  localparam logic [CW-1:0]     LAST_FULL = CW'(XLEN / B - 1);
  localparam logic [CW-1:0]     LAST_WORD = CW'(32 / B - 1);
  localparam logic [XLEN-1:0]   LO32      = XLEN'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] q, r, d;
  logic            qsign, rsign, word_r;
  logic            word, neg_a, neg_b, dz;
  logic [XLEN-1:0] a_w, b_w, mag_a, mag_b, a_load;
  logic [XLEN-1:0] q_step, r_step, q_adj, r_adj;
  logic [XLEN:0]   rs, diff;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x, input logic w);
    logic [XLEN-1:0] y;
    y = x;
    if (w) y = (x & LO32) | (x[31] ? ~LO32 : '0);
    return y;
  endfunction

  // Operand preparation: word ops are masked to 32 bits and pre-shifted to the top
  // of the quotient register so the same shift-out bit feeds the remainder.
  always_comb begin
    word   = (XLEN == 64) && W64;
    a_w    = word ? (SrcA & LO32) : SrcA;
    b_w    = word ? (SrcB & LO32) : SrcB;
    neg_a  = Signed & (word ? SrcA[31] : SrcA[XLEN-1]);
    neg_b  = Signed & (word ? SrcB[31] : SrcB[XLEN-1]);
    mag_a  = (neg_a ? -a_w : a_w) & (word ? LO32 : '1);
    mag_b  = (neg_b ? -b_w : b_w) & (word ? LO32 : '1);
    a_load = word ? (mag_a << (XLEN - 32)) : mag_a;
    dz     = (b_w == '0);
  end

  always_comb begin
    q_step = q;
    r_step = r;
    rs     = '0;
    diff   = '0;
    for (int unsigned i = 0; i < B; i++) begin
      rs     = {r_step, q_step[XLEN-1]};
      diff   = rs - {1'b0, d};
      q_step = {q_step[XLEN-2:0], ~diff[XLEN]};
      r_step = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
    end
    q_adj = sext_word(qsign ? -q_step : q_step, word_r);
    r_adj = sext_word(rsign ? -r_step : r_step, word_r);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (Start) state_nxt = dz ? DONE : DIV;
        DIV:     if (cnt == '0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // Results are loaded on the edge entering DONE so they are valid alongside Done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      word_r <= 1'b0;
      Quot   <= '0;
      Rem    <= '0;
    end else begin
      case (state)
        IDLE: if (Start && !Flush) begin
          word_r <= word;
          if (dz) begin
            Quot <= '1;
            Rem  <= sext_word(SrcA, word);
          end else begin
            q     <= a_load;
            r     <= '0;
            d     <= mag_b;
            qsign <= neg_a ^ neg_b;
            rsign <= neg_a;
            cnt   <= word ? LAST_WORD : LAST_FULL;
          end
        end
        DIV: if (!Flush) begin
          q <= q_step;
          r <= r_step;
          if (cnt == '0) begin
            Quot <= q_adj;
            Rem  <= r_adj;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_intdiv_iter.sv
// Scoreboard bench for intdiv_iter: XLEN=64/B=1 and XLEN=32/B=4 instances
// checked against a plain-arithmetic RISC-V division reference.
module tb_intdiv_iter;
  import cvw_pkg::*;

  localparam cvw_t P64 = '{XLEN: 64, IDIV_BITSPERCYCLE: 1};
  localparam cvw_t P32 = '{XLEN: 32, IDIV_BITSPERCYCLE: 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start64, flush64, signed64, w64;
  logic [63:0] a64, b64, quot64, rem64;
  logic        busy64, done64;
  logic        start32, flush32, signed32, w32;
  logic [31:0] a32, b32, quot32, rem32;
  logic        busy32, done32;

  intdiv_iter #(.P(P64)) u64 (
    .clk(clk), .reset(reset), .Start(start64), .Flush(flush64), .Signed(signed64), .W64(w64),
    .SrcA(a64), .SrcB(b64), .Busy(busy64), .Done(done64), .Quot(quot64), .Rem(rem64)
  );

  intdiv_iter #(.P(P32)) u32 (
    .clk(clk), .reset(reset), .Start(start32), .Flush(flush32), .Signed(signed32), .W64(w32),
    .SrcA(a32), .SrcB(b32), .Busy(busy32), .Done(done32), .Quot(quot32), .Rem(rem32)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          c0;
    int          lat;
  } exp_t;

  exp_t        sb64[$];
  exp_t        sb32[$];
  exp_t        m64, m32;
  logic [63:0] last_q64, last_r64;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics, computed directly with language arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  input logic wd, output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32v, b32v, q32, r32;
    a32v = a[31:0];
    b32v = b[31:0];
    q32  = '0;
    r32  = '0;
    if (wd) begin
      if (b32v == 32'd0) begin q32 = '1; r32 = a32v; end
      else if (s && a32v == 32'h8000_0000 && b32v == 32'hFFFF_FFFF) begin q32 = a32v; r32 = '0; end
      else if (s) begin
        q32 = 32'($signed(a32v) / $signed(b32v));
        r32 = 32'($signed(a32v) % $signed(b32v));
      end else begin
        q32 = a32v / b32v;
        r32 = a32v % b32v;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin q = '1; r = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
      else if (s) begin
        q = 64'($signed(a) / $signed(b));
        r = 64'($signed(a) % $signed(b));
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && done64) begin
      if (sb64.size() == 0) begin
        checks++; errors++;
        $display("FAIL done64_unexpected: got Done=1 expected Done=0");
      end else begin
        m64 = sb64.pop_front();
        chk("quot64", quot64, m64.q);
        chk("rem64", rem64, m64.r);
        chk("lat64", 64'(cyc - m64.c0 + 1), 64'(m64.lat));
        last_q64 = m64.q;
        last_r64 = m64.r;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done32) begin
      if (sb32.size() == 0) begin
        checks++; errors++;
        $display("FAIL done32_unexpected: got Done=1 expected Done=0");
      end else begin
        m32 = sb32.pop_front();
        chk("quot32", 64'(quot32), {32'd0, m32.q[31:0]});
        chk("rem32", 64'(rem32), {32'd0, m32.r[31:0]});
        chk("lat32", 64'(cyc - m32.c0 + 1), 64'(m32.lat));
      end
    end
  end

  task automatic wait_idle(input bit is64);
    int k;
    k = 0;
    while ((is64 ? busy64 : busy32) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout: Busy=1 after %0d cycles, expected 0", k);
    end
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    exp_t e;
    wait_idle(1'b1);
    @(posedge clk); #1;
    a64 = a; b64 = b; signed64 = s; w64 = w; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    ref_div(a, b, s, w, e.q, e.r);
    e.c0  = cyc;
    e.lat = (w ? (b[31:0] == 32'd0) : (b == 64'd0)) ? 1 : ((w ? 32 : 64) + 1);
    sb64.push_back(e);
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic w);
    exp_t e;
    wait_idle(1'b0);
    @(posedge clk); #1;
    a32 = a; b32 = b; signed32 = s; w32 = w; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    ref_div({32'd0, a}, {32'd0, b}, s, 1'b1, e.q, e.r);
    e.c0  = cyc;
    e.lat = (b == 32'd0) ? 1 : 32 / 4 + 1;
    sb32.push_back(e);
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 15));
      4:       return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    start64 = 1'b0; flush64 = 1'b0; signed64 = 1'b0; w64 = 1'b0; a64 = '0; b64 = '0;
    start32 = 1'b0; flush32 = 1'b0; signed32 = 1'b0; w32 = 1'b0; a32 = '0; b32 = '0;
    last_q64 = '0; last_r64 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy64", 64'(busy64), 64'd0);
    chk("rst_done64", 64'(done64), 64'd0);
    chk("rst_quot64", quot64, 64'd0);
    chk("rst_rem64", rem64, 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_quot32", 64'(quot32), 64'd0);

    // 100/7 with Busy profile across cycles 1..66
    issue64(64'd100, 64'd7, 1'b0, 1'b0);
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      chk($sformatf("busy_cycle%0d", c), 64'(busy64), 64'(c <= 65));
    end

    issue64(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0);
    issue64(64'd5, 64'd0, 1'b1, 1'b0);
    issue64(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0);
    issue64(64'hFFFF_FFFF_0000_0010, 64'd3, 1'b0, 1'b1);
    issue64(64'h0000_0000_8000_0000, 64'd1, 1'b0, 1'b1);
    issue64(64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1);
    issue64(64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1);

    // Start while busy is ignored
    issue64(64'd1000, 64'd10, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 a64 = 64'd77; b64 = 64'd0; start64 = 1'b1;
    @(posedge clk); #1 start64 = 1'b0;
    wait_idle(1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("busy_after_ignored_start", 64'(busy64), 64'd0);
    end

    // Flush in cycle 10: idle in cycle 11, no Done, results held
    issue64(64'hDEAD_BEEF_0000_1234, 64'd9, 1'b0, 1'b0);
    sb64.delete();
    repeat (9) @(posedge clk);
    #1 flush64 = 1'b1;
    @(posedge clk); #1 flush64 = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy64), 64'd0);
    chk("flush_done", 64'(done64), 64'd0);
    chk("flush_quot", quot64, last_q64);
    chk("flush_rem", rem64, last_r64);
    repeat (70) @(negedge clk);

    // Reset in the middle of a divide
    issue64(64'd123456789, 64'd321, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb64.delete();
    @(negedge clk);
    chk("midrst_busy", 64'(busy64), 64'd0);
    chk("midrst_done", 64'(done64), 64'd0);
    chk("midrst_quot", quot64, 64'd0);
    chk("midrst_rem", rem64, 64'd0);

    for (int i = 0; i < 40; i++)
      issue64(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    issue32(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
    issue32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue32(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      logic [63:0] x, y;
      x = rnd_op();
      y = rnd_op();
      issue32(x[31:0], y[31:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    k = 0;
    while ((sb64.size() != 0 || sb32.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb64.size() != 0 || sb32.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending results expected 0/0", sb64.size(), sb32.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
